alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single registered integer ALU between two requesters (req0: issue
//  pipeline, req1: auxiliary unit, e.g. address/CSR helper). Round-robin grant,
//  valid/ready on the request and response sides, one operation in flight.
//  Latches the operands and drives the ALU operand bus, then captures the
//  registered ALU result and returns it to the owning requester.
// PARAMETERS
//  XLEN        32  datapath width (operands, imm, result)
//  RESET_PRIO  0   requester that wins the first simultaneous request after reset (0/1)
// PORTS
//  clk          in   1     system clock, all logic on posedge
//  rst          in   1     synchronous, active-high reset
//  reqN_valid   in   1     N=0,1: request present; payload stable while valid && !ready
//  reqN_ready   out  1     N=0,1: request accepted this cycle
//  reqN_opcode  in   7     N=0,1: RV32 opcode (0010011 OP-IMM, 0110011 OP)
//  reqN_funct3  in   3     N=0,1: funct3
//  reqN_modbit  in   1     N=0,1: instr[30] (SUB/SRA/SRAI select)
//  reqN_imm     in   XLEN  N=0,1: sign-extended immediate
//  reqN_rs1     in   XLEN  N=0,1: operand 1
//  reqN_rs2     in   XLEN  N=0,1: operand 2
//  respN_valid  out  1     N=0,1: result for requester N available
//  respN_ready  in   1     N=0,1: requester N takes the result
//  resp_rd      out  XLEN  result, shared by both responses, valid with respN_valid
//  resp_err     out  1     only with ALU_ARB_ILLEGAL_EN: illegal opcode/funct3
//  alu_opcode/alu_funct3/alu_modbit/alu_imm/alu_rs1/alu_rs2  out  ALU operand bus
//  alu_rd       in   XLEN  registered ALU result
//  alu_comp     in   1     ALU completion flag
// BEHAVIOUR
//  - States: IDLE -> ISSUE -> CAPT -> RESP -> IDLE. Reset: IDLE, every output 0,
//    operand regs 0, last_grant = ~RESET_PRIO.
//  - IDLE: reqN_ready = grant_N combinationally; grant_N asserted only in IDLE.
//    Exactly one valid: that one granted. Both valid: the requester != last_grant.
//    On the accept edge latch payload and owner, set last_grant = owner -> ISSUE.
//  - ISSUE: alu_* driven from operand regs (held unchanged in all other states);
//    ALU registers its result on this edge -> CAPT.
//  - CAPT: if alu_comp=1, latch alu_rd into result reg -> RESP; else stay in CAPT.
//  - RESP: resp<owner>_valid=1, resp_rd=result reg, other resp valid=0. Held stable
//    until resp<owner>_ready=1; on that edge -> IDLE. No accept while in RESP.
//  - Latency: accept edge at cycle 0 -> respN_valid high from cycle 3. Minimum
//    spacing between accepts: 4 cycles.
//  - Requests asserted outside IDLE wait (ready=0); a pending request of the
//    non-owner is granted in the next IDLE cycle ahead of a new owner request.
//  - No arithmetic is performed here; payload is passed bit-exact to the ALU.
//  - rst in any state (incl. CAPT/RESP): next cycle IDLE, resp valids 0, in-flight
//    result discarded, no response ever returned for it.
//  - respN_ready while respN_valid=0 is ignored.
// CONFIGURATION
//  ALU_ARB_ILLEGAL_EN defined: in IDLE the accepted payload is checked; opcode not
//   0010011/0110011, or OP with modbit=1 and funct3 not in {000,101}, or OP-IMM
//   funct3 001 with modbit=1 -> skip ISSUE/CAPT, go straight to RESP with
//   resp_rd=0, resp_err=1 (respN_valid from cycle 1). resp_err=0 for legal ops,
//   0 when no resp valid.
//  Not defined: no resp_err port, no check; every accepted payload goes to the ALU.
// TESTING
//  1 rst, req0 ADDI rs1=5 imm=7 -> req0_ready cycle0, resp0_valid cycle3, rd=12.
//  2 after rst, req0 SUB 10-3 and req1 XOR 0xF0^0x0F same cycle, RESET_PRIO=0 ->
//    req0 first (rd=7), then req1 (rd=0xFF); both held again -> req0 next.
//  3 req1 SRAI rs1=0x80000000 imm=4, resp1_ready low 5 cycles -> resp1_valid and
//    rd=0xF8000000 held stable, req0_ready stays 0, completes on ready.
//  4 rst pulsed while in CAPT for req0 SLTU -> next cycle IDLE, resp valids 0,
//    no response for req0.
//  5 ALU_ARB_ILLEGAL_EN, req0 opcode 1100011 -> resp0_valid cycle1, err=1, rd=0;
//    without macro the payload reaches alu_opcode in ISSUE.
//  6 hold alu_comp=0 in CAPT 3 cycles -> stays CAPT; rd captured when comp=1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU operand-bus signals of alu_arbiter.
// resp_err exists only when ALU_ARB_ILLEGAL_EN is defined.
interface alu_arbiter_if #(
   parameter int XLEN = 32
);
   logic            req0_valid;
   logic            req0_ready;
   logic [6:0]      req0_opcode;
   logic [2:0]      req0_funct3;
   logic            req0_modbit;
   logic [XLEN-1:0] req0_imm;
   logic [XLEN-1:0] req0_rs1;
   logic [XLEN-1:0] req0_rs2;
   logic            req1_valid;
   logic            req1_ready;
   logic [6:0]      req1_opcode;
   logic [2:0]      req1_funct3;
   logic            req1_modbit;
   logic [XLEN-1:0] req1_imm;
   logic [XLEN-1:0] req1_rs1;
   logic [XLEN-1:0] req1_rs2;
   logic            resp0_valid;
   logic            resp0_ready;
   logic            resp1_valid;
   logic            resp1_ready;
   logic [XLEN-1:0] resp_rd;
`ifdef ALU_ARB_ILLEGAL_EN
   logic            resp_err;
`endif
   logic [6:0]      alu_opcode;
   logic [2:0]      alu_funct3;
   logic            alu_modbit;
   logic [XLEN-1:0] alu_imm;
   logic [XLEN-1:0] alu_rs1;
   logic [XLEN-1:0] alu_rs2;
   logic [XLEN-1:0] alu_rd;
   logic            alu_comp;

   modport slave (
      input  req0_valid, req0_opcode, req0_funct3, req0_modbit,
      input  req0_imm, req0_rs1, req0_rs2,
      input  req1_valid, req1_opcode, req1_funct3, req1_modbit,
      input  req1_imm, req1_rs1, req1_rs2,
      input  resp0_ready, resp1_ready, alu_rd, alu_comp,
      output req0_ready, req1_ready, resp0_valid, resp1_valid,
`ifdef ALU_ARB_ILLEGAL_EN
      output resp_err,
`endif
      output resp_rd, alu_opcode, alu_funct3, alu_modbit,
      output alu_imm, alu_rs1, alu_rs2
   );

   modport master (
      output req0_valid, req0_opcode, req0_funct3, req0_modbit,
      output req0_imm, req0_rs1, req0_rs2,
      output req1_valid, req1_opcode, req1_funct3, req1_modbit,
      output req1_imm, req1_rs1, req1_rs2,
      output resp0_ready, resp1_ready, alu_rd, alu_comp,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid,
`ifdef ALU_ARB_ILLEGAL_EN
      input  resp_err,
`endif
      input  resp_rd, alu_opcode, alu_funct3, alu_modbit,
      input  alu_imm, alu_rs1, alu_rs2
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU between two requesters.
// Optional ALU_ARB_ILLEGAL_EN: illegal encodings bypass the ALU with resp_err=1.
module alu_arbiter #(
   parameter int XLEN       = 32,
   parameter int RESET_PRIO = 0
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_CAPT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;
   localparam logic [6:0] OPC_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP  = 7'b0110011;

   logic [1:0]      state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_grant_q, last_grant_d;
   logic [6:0]      opcode_q, opcode_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            modbit_q, modbit_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [XLEN-1:0] rs1_q, rs1_d;
   logic [XLEN-1:0] rs2_q, rs2_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            gnt0, gnt1;
   logic            resp_act;
   logic [6:0]      sel_opcode;
   logic [2:0]      sel_funct3;
   logic            sel_modbit;
   logic [XLEN-1:0] sel_imm, sel_rs1, sel_rs2;
`ifdef ALU_ARB_ILLEGAL_EN
   logic            err_q, err_d;
   logic            illegal;
`endif

   // Grants only in IDLE; on a tie the requester not served last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == S_IDLE) begin
         gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
         gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
      end
   end

   always_comb begin
      sel_opcode = gnt1 ? bus.req1_opcode : bus.req0_opcode;
      sel_funct3 = gnt1 ? bus.req1_funct3 : bus.req0_funct3;
      sel_modbit = gnt1 ? bus.req1_modbit : bus.req0_modbit;
      sel_imm    = gnt1 ? bus.req1_imm    : bus.req0_imm;
      sel_rs1    = gnt1 ? bus.req1_rs1    : bus.req0_rs1;
      sel_rs2    = gnt1 ? bus.req1_rs2    : bus.req0_rs2;
   end

`ifdef ALU_ARB_ILLEGAL_EN
   always_comb begin
      illegal = 1'b0;
      if (sel_opcode != OPC_IMM && sel_opcode != OPC_OP)
         illegal = 1'b1;
      else if (sel_opcode == OPC_OP && sel_modbit &&
               sel_funct3 != 3'b000 && sel_funct3 != 3'b101)
         illegal = 1'b1;
      else if (sel_opcode == OPC_IMM && sel_modbit &&
               sel_funct3 == 3'b001)
         illegal = 1'b1;
   end
`endif

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      opcode_d     = opcode_q;
      funct3_d     = funct3_q;
      modbit_d     = modbit_q;
      imm_d        = imm_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      result_d     = result_q;
`ifdef ALU_ARB_ILLEGAL_EN
      err_d        = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (gnt0 | gnt1) begin
               owner_d      = gnt1;
               last_grant_d = gnt1;
               opcode_d     = sel_opcode;
               funct3_d     = sel_funct3;
               modbit_d     = sel_modbit;
               imm_d        = sel_imm;
               rs1_d        = sel_rs1;
               rs2_d        = sel_rs2;
               state_d      = S_ISSUE;
`ifdef ALU_ARB_ILLEGAL_EN
               err_d        = illegal;
               if (illegal) begin
                  result_d = '0;
                  state_d  = S_RESP;
               end
`endif
            end
         end
         S_ISSUE: state_d = S_CAPT;
         S_CAPT: begin
            if (bus.alu_comp) begin
               result_d = bus.alu_rd;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (owner_q ? bus.resp1_ready : bus.resp0_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= (RESET_PRIO == 0);
         opcode_q     <= '0;
         funct3_q     <= '0;
         modbit_q     <= 1'b0;
         imm_q        <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         result_q     <= '0;
`ifdef ALU_ARB_ILLEGAL_EN
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         opcode_q     <= opcode_d;
         funct3_q     <= funct3_d;
         modbit_q     <= modbit_d;
         imm_q        <= imm_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         result_q     <= result_d;
`ifdef ALU_ARB_ILLEGAL_EN
         err_q        <= err_d;
`endif
      end
   end

   assign resp_act        = (state_q == S_RESP);
   assign bus.req0_ready  = gnt0;
   assign bus.req1_ready  = gnt1;
   assign bus.resp0_valid = resp_act & ~owner_q;
   assign bus.resp1_valid = resp_act & owner_q;
   assign bus.resp_rd     = resp_act ? result_q : '0;
`ifdef ALU_ARB_ILLEGAL_EN
   assign bus.resp_err    = resp_act & err_q;
`endif

   // The operand bus always mirrors the latched payload.
   assign bus.alu_opcode  = opcode_q;
   assign bus.alu_funct3  = funct3_q;
   assign bus.alu_modbit  = modbit_q;
   assign bus.alu_imm     = imm_q;
   assign bus.alu_rs1     = rs1_q;
   assign bus.alu_rs2     = rs2_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a response scoreboard for alu_arbiter.
// A small registered ALU model drives alu_rd from the operand bus.
module tb_alu_arbiter;
   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011;

   typedef struct {
      logic        port;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   alu_arbiter_if #(.XLEN(32)) bus ();

   alu_arbiter #(.XLEN(32), .RESET_PRIO(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(
      input logic [6:0] op, input logic [2:0] f3, input logic m,
      input logic [31:0] imm, input logic [31:0] a, input logic [31:0] bi);
      logic [31:0] b;
      logic [31:0] r;
      if (op == OPI) b = imm;
      else if (op == OPR) b = bi;
      else return 32'hDEAD_BEEF;
      case (f3)
         3'b000: r = (op == OPR && m) ? a - b : a + b;
         3'b001: r = a << b[4:0];
         3'b010: r = {31'd0, $signed(a) < $signed(b)};
         3'b011: r = {31'd0, a < b};
         3'b100: r = a ^ b;
         3'b101: r = m ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   always @(posedge clk)
      bus.alu_rd <= alu_fn(bus.alu_opcode, bus.alu_funct3, bus.alu_modbit,
                           bus.alu_imm, bus.alu_rs1, bus.alu_rs2);

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Scoreboard monitor: pops one expectation per completed response.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.resp0_valid && bus.resp1_valid) begin
            checks++;
            failures++;
            $display("FAIL mon_both_valid: both response valids high");
         end
         if ((bus.resp0_valid && bus.resp0_ready) ||
             (bus.resp1_valid && bus.resp1_ready)) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL mon_unexpected: resp1_valid=%0b rd=%h with empty queue",
                        bus.resp1_valid, bus.resp_rd);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("mon_port", {31'd0, bus.resp1_valid}, {31'd0, e.port});
               check("mon_rd", bus.resp_rd, e.rd);
`ifdef ALU_ARB_ILLEGAL_EN
               check("mon_err", {31'd0, bus.resp_err}, {31'd0, e.err});
`endif
            end
         end
      end
   end

   task automatic push(input logic port, input logic [31:0] rd, input logic err);
      exp_t e;
      e.port = port;
      e.rd   = rd;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input logic port, input logic [6:0] op,
                          input logic [2:0] f3, input logic m,
                          input logic [31:0] imm, input logic [31:0] a,
                          input logic [31:0] b);
      if (!port) begin
         bus.req0_valid = 1'b1; bus.req0_opcode = op; bus.req0_funct3 = f3;
         bus.req0_modbit = m; bus.req0_imm = imm; bus.req0_rs1 = a;
         bus.req0_rs2 = b;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_opcode = op; bus.req1_funct3 = f3;
         bus.req1_modbit = m; bus.req1_imm = imm; bus.req1_rs1 = a;
         bus.req1_rs2 = b;
      end
   endtask

   task automatic clr_req(input logic port);
      if (!port) bus.req0_valid = 1'b0;
      else bus.req1_valid = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
      bus.alu_comp = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_rst_resp0"}, {31'd0, bus.resp0_valid}, 32'd0);
      check({tag, "_rst_resp1"}, {31'd0, bus.resp1_valid}, 32'd0);
      check({tag, "_rst_rd"}, bus.resp_rd, 32'd0);
      check({tag, "_rst_aluop"}, {25'd0, bus.alu_opcode}, 32'd0);
      check({tag, "_rst_alurs1"}, bus.alu_rs1, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Waits from a posedge+1 point for any grant, bounded.
   task automatic wait_grant(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.req0_ready || bus.req1_ready) && n < 30);
      check({name, "_granted"}, {31'd0, bus.req0_ready | bus.req1_ready}, 32'd1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req0_opcode = '0; bus.req0_funct3 = '0; bus.req0_modbit = 1'b0;
      bus.req0_imm = '0; bus.req0_rs1 = '0; bus.req0_rs2 = '0;
      bus.req1_opcode = '0; bus.req1_funct3 = '0; bus.req1_modbit = 1'b0;
      bus.req1_imm = '0; bus.req1_rs1 = '0; bus.req1_rs2 = '0;

      // 1: ADDI latency
      do_reset("t1");
      set_req(0, OPI, 3'b000, 1'b0, 32'd7, 32'd5, 32'd0);
      @(negedge clk);
      check("t1_ready0", {31'd0, bus.req0_ready}, 32'd1);
      push(0, 32'd12, 1'b0);
      @(posedge clk); #1 clr_req(0);
      @(negedge clk);
      check("t1_c1_valid", {31'd0, bus.resp0_valid}, 32'd0);
      check("t1_c1_aluimm", bus.alu_imm, 32'd7);
      @(negedge clk);
      check("t1_c2_valid", {31'd0, bus.resp0_valid}, 32'd0);
      @(negedge clk);
      check("t1_c3_valid", {31'd0, bus.resp0_valid}, 32'd1);
      check("t1_c3_rd", bus.resp_rd, 32'd12);
      drain("t1");

      // 2: simultaneous requests, round robin
      do_reset("t2");
      set_req(0, OPR, 3'b000, 1'b1, 32'd0, 32'd10, 32'd3);
      set_req(1, OPR, 3'b100, 1'b0, 32'd0, 32'hF0, 32'h0F);
      @(negedge clk);
      check("t2_first_r0", {31'd0, bus.req0_ready}, 32'd1);
      check("t2_first_r1", {31'd0, bus.req1_ready}, 32'd0);
      push(0, 32'd7, 1'b0);
      @(posedge clk); #1 clr_req(0);
      wait_grant("t2_second");
      check("t2_second_r1", {31'd0, bus.req1_ready}, 32'd1);
      push(1, 32'hFF, 1'b0);
      @(posedge clk); #1;
      set_req(0, OPR, 3'b000, 1'b0, 32'd0, 32'd1, 32'd2);
      set_req(1, OPR, 3'b111, 1'b0, 32'd0, 32'hFF, 32'h0F);
      wait_grant("t2_third");
      check("t2_third_r0", {31'd0, bus.req0_ready}, 32'd1);
      check("t2_third_r1", {31'd0, bus.req1_ready}, 32'd0);
      push(0, 32'd3, 1'b0);
      @(posedge clk); #1 clr_req(0);
      wait_grant("t2_fourth");
      check("t2_fourth_r1", {31'd0, bus.req1_ready}, 32'd1);
      push(1, 32'h0F, 1'b0);
      @(posedge clk); #1 clr_req(1);
      drain("t2");

      // 3: SRAI with response back-pressure
      do_reset("t3");
      bus.resp1_ready = 1'b0;
      set_req(1, OPI, 3'b101, 1'b1, 32'd4, 32'h8000_0000, 32'd0);
      wait_grant("t3_r1");
      push(1, 32'hF800_0000, 1'b0);
      @(posedge clk); #1 clr_req(1);
      set_req(0, OPI, 3'b000, 1'b0, 32'd1, 32'd0, 32'd0);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.resp1_valid && n < 10);
      end
      for (int k = 0; k < 5; k++) begin
         check("t3_hold_valid", {31'd0, bus.resp1_valid}, 32'd1);
         check("t3_hold_rd", bus.resp_rd, 32'hF800_0000);
         check("t3_hold_r0", {31'd0, bus.req0_ready}, 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 bus.resp1_ready = 1'b1;
      wait_grant("t3_r0");
      check("t3_r0_ready", {31'd0, bus.req0_ready}, 32'd1);
      push(0, 32'd1, 1'b0);
      @(posedge clk); #1 clr_req(0);
      drain("t3");

      // 4: reset while in CAPT discards the operation
      do_reset("t4");
      set_req(0, OPR, 3'b011, 1'b0, 32'd0, 32'd1, 32'd2);
      @(negedge clk);
      check("t4_ready0", {31'd0, bus.req0_ready}, 32'd1);
      @(posedge clk); #1 clr_req(0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("t4_capt_valid", {31'd0, bus.resp0_valid}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t4_post_alurs1", bus.alu_rs1, 32'd0);
      for (int k = 0; k < 6; k++) begin
         check("t4_no_resp", {31'd0, bus.resp0_valid}, 32'd0);
         @(negedge clk);
      end
      check("t4_queue", exp_q.size(), 32'd0);
      @(posedge clk); #1;

      // 5: illegal opcode
      set_req(0, 7'b1100011, 3'b000, 1'b0, 32'd8, 32'd1, 32'd1);
      wait_grant("t5");
`ifdef ALU_ARB_ILLEGAL_EN
      push(0, 32'd0, 1'b1);
      @(posedge clk); #1 clr_req(0);
      @(negedge clk);
      check("t5_c1_valid", {31'd0, bus.resp0_valid}, 32'd1);
      check("t5_c1_err", {31'd0, bus.resp_err}, 32'd1);
      check("t5_c1_rd", bus.resp_rd, 32'd0);
`else
      push(0, 32'hDEAD_BEEF, 1'b0);
      @(posedge clk); #1 clr_req(0);
      @(negedge clk);
      check("t5_issue_aluop", {25'd0, bus.alu_opcode}, 32'h63);
`endif
      drain("t5");

      // 6: completion flag held low in CAPT
      bus.alu_comp = 1'b0;
      set_req(0, OPR, 3'b000, 1'b0, 32'd0, 32'd100, 32'd23);
      wait_grant("t6");
      push(0, 32'd123, 1'b0);
      @(posedge clk); #1 clr_req(0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("t6_wait_valid", {31'd0, bus.resp0_valid}, 32'd0);
         @(posedge clk); #1;
      end
      bus.alu_comp = 1'b1;
      @(negedge clk);
      check("t6_c5_valid", {31'd0, bus.resp0_valid}, 32'd0);
      @(negedge clk);
      check("t6_c6_valid", {31'd0, bus.resp0_valid}, 32'd1);
      check("t6_c6_rd", bus.resp_rd, 32'd123);
      drain("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
